// File: rtl/prog_loader.sv
// Framed byte stream -> 32-bit program-memory writes; holds the core until the image checksum verifies.
// Latency 5+4N cycles from start to done at full rate. byte_ready is registered and stalls on byte_valid gaps.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_buf;
  logic [7:0]  chk;
  logic        xfer;
  logic [15:0] len_in;

  assign xfer   = byte_valid && byte_ready;
  assign len_in = {byte_data, len[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      asm_buf    <= '0;
      chk        <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LEN0;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            chk        <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
          end
        end
        S_LEN0: begin
          if (xfer) begin
            len[7:0] <= byte_data;
            state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            len <= len_in;
            if ({16'd0, len_in} > MAX_WORDS) begin
              state      <= S_ERROR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
            end else if (len_in == 16'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            chk      <= chk ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            asm_buf  <= {byte_data, asm_buf[23:8]};
            // Fourth byte completes the word; earlier bytes sit LSB-first in asm_buf.
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= {byte_data, asm_buf};
              wr_addr  <= word_idx[ADDR_W-1:0];
              word_idx <= word_idx + 16'd1;
              if (word_idx + 16'd1 == len) state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == chk) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware program loader for the RISC-V core's program memory. It receives a framed byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and writes them to consecutive program-memory word addresses starting at 0. It holds the core in reset until the whole image has loaded and its checksum matches, then releases the core. It is the hardware counterpart of the bench-side program-memory initialisation.

## Interface
- ADDR_W, 10, program-memory word-address width; maximum image size is 2**ADDR_W words
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERROR, ignored in all other states
- byte_valid  in  1  source presents byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid && byte_ready
- wr_en  out  1  program-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  instruction word
- core_hold  out  1  high keeps the core in reset
- done  out  1  image loaded and verified
- error  out  1  load aborted

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes with each word least-significant byte first, then CHK = XOR of all payload bytes.
- States:
  - IDLE: byte_ready=0; start -> LEN0.
  - LEN0: capture LEN_LO -> LEN1.
  - LEN1: capture LEN_HI. N > 2**ADDR_W -> ERROR; N = 0 -> CHK with expected checksum 0x00; otherwise -> DATA.
  - DATA: shift bytes into the word assembler and XOR each byte into the running checksum. On the 4th byte of a word, register wr_data and wr_addr (= word index) and pulse wr_en the next cycle. After word N-1 -> CHK.
  - CHK: CHK == running checksum -> DONE, else -> ERROR.
  - DONE: done=1, core_hold=0; start -> LEN0.
  - ERROR: error=1, core_hold=1; start -> LEN0.
- On a start pulse: clear done, error, the checksum, the byte counter and the word index, and set core_hold=1 in the same edge.
- Byte and word counters are wide enough that N = 2**ADDR_W does not wrap before the CHK transition. The last wr_addr is 2**ADDR_W − 1.
- Reset (rst=1) at any point, including mid-load: state IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=1, done=0, error=0. The partial image is abandoned and no further writes occur.

## Timing
- byte_ready is registered: high in LEN0, LEN1, DATA and CHK, low elsewhere. It rises the cycle after start is sampled.
- One byte per cycle maximum. Gaps on byte_valid are allowed anywhere; state and counters hold while byte_valid=0.
- wr_en is high exactly one cycle, the cycle after the 4th byte of a word is accepted. wr_addr and wr_data are stable during that cycle.
- done or error rises, and core_hold changes, the cycle after CHK is accepted (or after LEN_HI for oversize). The final wr_en always precedes done by at least one cycle.
- Minimum load latency, start to done, at full rate: 1 + 2 + 4·N + 1 + 1 cycles.
- byte_valid in IDLE, DONE or ERROR is not consumed, since byte_ready=0.

## Test plan
- ADDR_W=4, N=1, payload 13 05 00 00, CHK=0x16 -> one wr_en with wr_addr=0, wr_data=0x00000513; done=1 and core_hold=0 the cycle after CHK; error=0.
- N=2, words 0x00500093 and 0x00A00113 with random byte_valid gaps -> wr_en at addr 0 then addr 1 with those values; done=1; no write when byte_valid=0.
- N=0, CHK=0x00 -> no wr_en; done=1 after CHK. Repeat with CHK=0x01 -> error=1, core_hold=1, done=0.
- ADDR_W=4, N=17 -> ERROR right after LEN_HI, byte_ready=0, no wr_en. Repeat with N=16 and a correct checksum -> 16 writes, last at wr_addr=15, done=1.
- rst=1 after 2 of 3 words have been written -> next cycle all outputs at reset values. A new start followed by a full N=1 frame loads correctly into addr 0.
- start pulsed during DATA -> ignored and the load completes normally. start pulsed in DONE -> done drops and core_hold rises on the next edge, and a new frame is accepted.
